// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TX FIFO plus 8N1 serialiser, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic        sel,
  output logic [31:0] rd,
  output logic        txd,
  output logic        irq
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count, w_count_d;
  logic          r_ovf;
  logic [15:0]   r_div, r_adiv, w_adiv_d, r_cnt, w_cnt_d;
  logic [7:0]    r_shreg, w_shreg_d;
  logic [2:0]    r_bit, w_bit_d;
  logic          r_par, w_par_d;
  logic          r_txd, w_txd_d;
  logic          r_irq;
  state_t        r_state, w_state_d;

  logic        w_sel, w_wr, w_push, w_push_ok, w_pop, w_full, w_empty, w_busy;
  logic [1:0]  w_cnt_sat;
  logic [7:0]  w_head;
  logic        w_unused;

  assign w_sel     = (a[31:4] == BASE_ADDR[31:4]);
  assign w_wr      = we & w_sel;
  assign w_push    = w_wr & (a[3:2] == 2'd0);
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_head    = r_mem[r_rptr];
  assign w_busy    = (r_state != StIdle);
  assign w_cnt_sat = (r_count > CW'(2)) ? 2'd3 : r_count[1:0];
  assign w_unused  = ^{a[1:0], wd[31:16]};

  assign sel = w_sel;
  assign txd = r_txd;
  assign irq = r_irq;

  always_comb begin
    rd = 32'd0;
    if (w_sel) begin
      unique case (a[3:2])
        2'd1:    rd = {25'd0, PAR_EN, r_ovf, w_full, w_empty, w_busy, w_cnt_sat};
        2'd2:    rd = {16'd0, r_div};
        default: rd = 32'd0;
      endcase
    end
  end

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push_ok, w_pop})
      2'b10:   w_count_d = r_count + CW'(1);
      2'b01:   w_count_d = r_count - CW'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_bit_d   = r_bit;
    w_shreg_d = r_shreg;
    w_adiv_d  = r_adiv;
    w_par_d   = r_par;
    w_pop     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shreg_d = w_head;
          w_par_d   = ^w_head;
          w_adiv_d  = r_div;
          w_cnt_d   = r_div - 16'd1;
          w_state_d = StStart;
        end
      end
      StStart: begin
        if (r_cnt == 16'd0) begin
          w_cnt_d   = r_adiv - 16'd1;
          w_bit_d   = 3'd0;
          w_state_d = StData;
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
      StData: begin
        if (r_cnt == 16'd0) begin
          w_cnt_d   = r_adiv - 16'd1;
          w_shreg_d = {1'b0, r_shreg[7:1]};
          w_bit_d   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_d = StParity;
`else
            w_state_d = StStop;
`endif
          end
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (r_cnt == 16'd0) begin
          w_cnt_d   = r_adiv - 16'd1;
          w_state_d = StStop;
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
`endif
      StStop: begin
        if (r_cnt == 16'd0) begin
          // Back-to-back frames: pop straight into START with no idle gap.
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shreg_d = w_head;
            w_par_d   = ^w_head;
            w_adiv_d  = r_div;
            w_cnt_d   = r_div - 16'd1;
            w_state_d = StStart;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // txd is registered from next-state values so the line never glitches.
  always_comb begin
    w_txd_d = 1'b1;
    unique case (w_state_d)
      StStart:  w_txd_d = 1'b0;
      StData:   w_txd_d = w_shreg_d[0];
      StParity: w_txd_d = w_par_d;
      default:  w_txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= wd[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_div   <= DEFAULT_DIV;
    end else begin
      r_count <= w_count_d;
      if (w_push_ok) r_wptr <= r_wptr + PW'(1);
      if (w_pop)     r_rptr <= r_rptr + PW'(1);
      if (w_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end else if (w_wr && (a[3:2] == 2'd1) && wd[5]) begin
        r_ovf <= 1'b0;
      end
      if (w_wr && (a[3:2] == 2'd2)) begin
        r_div <= (wd[15:0] < 16'd2) ? 16'd2 : wd[15:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_cnt   <= 16'd0;
      r_bit   <= 3'd0;
      r_shreg <= 8'd0;
      r_adiv  <= DEFAULT_DIV;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
      r_irq   <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_bit   <= w_bit_d;
      r_shreg <= w_shreg_d;
      r_adiv  <= w_adiv_d;
      r_par   <= w_par_d;
      r_txd   <= w_txd_d;
      r_irq   <= (w_count_d == '0) && (w_state_d == StIdle);
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: predicts the serial waveform frame by frame and checks
// txd, irq and register reads each cycle against it.
module tb_mmio_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n, we;
  logic [31:0] a, wd;
  logic        sel;
  logic [31:0] rd;
  logic        txd, irq;

  mmio_uart_tx dut (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .a       (a),
    .wd      (wd),
    .sel     (sel),
    .rd      (rd),
    .txd     (txd),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    int          cyc;
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  bit  exp_q[$];
  op_t sched[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line levels for one frame, each bit held for div cycles.
  task automatic add_frame(input logic [7:0] b, input int div);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (PAR) bits.push_back(^b);
    bits.push_back(1'b1);
    foreach (bits[i]) repeat (div) exp_q.push_back(bits[i]);
  endtask

  function automatic logic [31:0] status_word(input bit ovf, input int occ, input bit busy);
    logic [1:0] c;
    c = (occ > 3) ? 2'd3 : 2'(occ);
    return {25'd0, PAR, ovf, (occ == DEPTH), (occ == 0), busy, c};
  endfunction

  task automatic add_op(input int c, input bit r, input logic [31:0] ad, input logic [31:0] d);
    op_t op;
    op = '{cyc: c, is_rd: r, addr: ad, data: d};
    sched.push_back(op);
  endtask

  task automatic bus_write(input logic [31:0] ad, input logic [31:0] d);
    we = 1'b1; a = ad; wd = d;
    tick();
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] ad, output logic [31:0] d);
    a = ad;
    #1;
    d = rd;
  endtask

  // Cycle 0 is the cycle of the first scheduled write; the line leaves idle at cycle 2.
  task automatic run(input string tag, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      logic e_txd, e_irq;
      we = 1'b0;
      e_txd = (c >= 2 && (c - 2) < exp_q.size()) ? exp_q[c - 2] : 1'b1;
      e_irq = (exp_q.size() == 0) ? 1'b1 : !(c >= 1 && c < 2 + exp_q.size());
      check($sformatf("%s txd@%0d", tag, c), {31'd0, txd}, {31'd0, e_txd});
      check($sformatf("%s irq@%0d", tag, c), {31'd0, irq}, {31'd0, e_irq});
      foreach (sched[i]) begin
        if (sched[i].cyc == c) begin
          if (sched[i].is_rd) begin
            a = sched[i].addr;
            #1;
            check($sformatf("%s rd[%0h]@%0d", tag, sched[i].addr, c), rd, sched[i].data);
          end else begin
            we = 1'b1; a = sched[i].addr; wd = sched[i].data;
          end
        end
      end
      tick();
    end
    we = 1'b0;
    exp_q.delete();
    sched.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  b [10];
    int          div, n;

    reset_n = 1'b0; we = 1'b0; a = 32'd0; wd = 32'd0;
    repeat (3) tick();
    reset_n = 1'b1;

    // Reset state and decode
    check("reset txd", {31'd0, txd}, 32'd1);
    check("reset irq", {31'd0, irq}, 32'd1);
    bus_read(32'h408, r); check("reset bauddiv", r, 32'd434);
    bus_read(32'h404, r); check("reset status", r, status_word(0, 0, 0));
    check("sel in window", {31'd0, sel}, 32'd1);
    bus_read(32'h400, r); check("txdata reads 0", r, 32'd0);
    bus_read(32'h40C, r); check("reserved reads 0", r, 32'd0);
    bus_read(32'h410, r); check("outside rd", r, 32'd0);
    check("outside sel", {31'd0, sel}, 32'd0);

    // BAUDDIV clamp and reserved write
    bus_write(32'h408, 32'd1);     bus_read(32'h408, r); check("div clamp 1", r, 32'd2);
    bus_write(32'h408, 32'd0);     bus_read(32'h408, r); check("div clamp 0", r, 32'd2);
    bus_write(32'h408, 32'h1_0007); bus_read(32'h408, r); check("div 16b", r, 32'd7);
    bus_write(32'h40C, 32'hFFFF);  bus_read(32'h408, r); check("reserved wr", r, 32'd7);
    bus_write(32'h410, 32'h55);    bus_read(32'h404, r); check("outside wr", r, status_word(0, 0, 0));

    // Single byte, div 4
    bus_write(32'h408, 32'd4);
    add_frame(8'h55, 4);
    add_op(0, 0, 32'h400, 32'h55);
    add_op(10, 1, 32'h404, status_word(0, 0, 1));
    add_op(42, 1, 32'h404, status_word(0, 0, 0));
    run("single", 44);

    // Back-to-back, div 2
    bus_write(32'h408, 32'd2);
    add_frame(8'hA5, 2); add_frame(8'h3C, 2);
    add_op(0, 0, 32'h400, 32'hA5);
    add_op(1, 0, 32'h400, 32'h3C);
    add_op(42, 1, 32'h404, status_word(0, 0, 0));
    run("b2b", 44);

    // Overflow; divisor changed mid-frame applies from the second frame
    bus_write(32'h408, 32'd1000);
    for (int i = 0; i < 10; i++) begin
      b[i] = 8'($urandom);
      add_op(i, 0, 32'h400, {24'd0, b[i]});
    end
    add_frame(b[0], 1000);
    for (int i = 1; i < 9; i++) add_frame(b[i], 3);
    add_op(10, 1, 32'h404, status_word(1, 8, 1));
    add_op(11, 0, 32'h404, 32'h20);
    add_op(12, 1, 32'h404, status_word(0, 8, 1));
    add_op(13, 0, 32'h408, 32'd3);
    add_op(14, 1, 32'h408, 32'd3);
    add_op(10270, 1, 32'h404, status_word(0, 0, 0));
    run("ovf", 10272);

    // Reset during data bit 3 (cycles 18..21 at div 4)
    bus_write(32'h408, 32'd4);
    add_frame(8'h00, 4); add_frame(8'h11, 4); add_frame(8'h22, 4);
    add_op(0, 0, 32'h400, 32'h00);
    add_op(1, 0, 32'h400, 32'h11);
    add_op(2, 0, 32'h400, 32'h22);
    run("midrst", 19);
    check("midrst txd before", {31'd0, txd}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("midrst txd async", {31'd0, txd}, 32'd1);
    check("midrst irq async", {31'd0, irq}, 32'd1);
    tick(); tick();
    reset_n = 1'b1;
    add_op(50, 1, 32'h404, status_word(0, 0, 0));
    add_op(51, 1, 32'h408, 32'd434);
    run("postrst", 100);

`ifdef UART_TX_PARITY_EN
    bus_write(32'h408, 32'd2);
    add_frame(8'h07, 2);
    add_op(0, 0, 32'h400, 32'h07);
    add_op(21, 1, 32'h404, status_word(0, 0, 1));
    add_op(24, 1, 32'h404, status_word(0, 0, 0));
    run("parity", 26);
`endif

    // Randomised bursts
    for (int it = 0; it < 8; it++) begin
      div = $urandom_range(2, 5);
      n   = $urandom_range(1, 9);
      bus_write(32'h408, 32'(div));
      for (int i = 0; i < n; i++) begin
        logic [7:0] v;
        v = 8'($urandom);
        add_frame(v, div);
        add_op(i, 0, 32'h400, {$urandom_range(0, 255), v} & 32'h0000_FFFF);
      end
      add_op(n, 1, 32'h404, (n == 1) ? status_word(0, 1, 0) : status_word(0, n - 1, 1));
      add_op(3 + exp_q.size(), 1, 32'h404, status_word(0, 0, 0));
      run($sformatf("rnd%0d", it), 5 + exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
